// File: rtl/pic_prog_pkg.sv
// rtl/pic_prog_pkg.sv - shared command and state encodings for the PIC program loader
package pic_prog_pkg;

   localparam int FRAME_W = 16;

   localparam logic [3:0] CMD_NOP        = 4'h0;
   localparam logic [3:0] CMD_SET_ADDR   = 4'h1;
   localparam logic [3:0] CMD_WRITE_INC  = 4'h2;
   localparam logic [3:0] CMD_WRITE_HOLD = 4'h3;
   localparam logic [3:0] CMD_END        = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      EXEC  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/prog_sync_edge.sv
// rtl/prog_sync_edge.sv - multi-flop synchroniser for one async bit with a rise pulse
module prog_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pic_prog_loader.sv
// rtl/pic_prog_loader.sv - serial frame receiver that writes instruction words into program RAM
// and holds the core in reset while a load session is in progress.
module pic_prog_loader
   import pic_prog_pkg::*;
#(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 12,
   parameter int CMD_W       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              prog_en,
   input  logic              prog_sclk,
   input  logic              prog_sdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              core_reset,
   output logic              busy,
   output logic [DATA_W-1:0] checksum,
   output logic              frame_err
);

   localparam int FW = CMD_W + DATA_W;

   logic en_s, en_rise, sclk_rise, sdata_s;
   logic sclk_s_unused, sdata_rise_unused;

   prog_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_en (
      .clock(clock), .reset(reset), .d(prog_en), .q(en_s), .rise(en_rise));
   prog_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clock(clock), .reset(reset), .d(prog_sclk), .q(sclk_s_unused), .rise(sclk_rise));
   prog_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdata (
      .clock(clock), .reset(reset), .d(prog_sdata), .q(sdata_s), .rise(sdata_rise_unused));

   state_t            state, state_d;
   logic [3:0]        cnt, cnt_d;
   logic [FW-1:0]     sr, sr_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d, sum_d;
   logic              we_d, core_reset_d, err_d;
   logic              inc_pend, inc_pend_d;
   logic [CMD_W-1:0]  cmd;
   logic [DATA_W-1:0] payload;

   assign cmd     = sr[FW-1:DATA_W];
   assign payload = sr[DATA_W-1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         sr         <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         core_reset <= 1'b1;
         checksum   <= '0;
         frame_err  <= 1'b0;
         inc_pend   <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         sr         <= sr_d;
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
         mem_we     <= we_d;
         core_reset <= core_reset_d;
         checksum   <= sum_d;
         frame_err  <= err_d;
         inc_pend   <= inc_pend_d;
      end
   end

   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      sr_d         = sr;
      addr_d       = mem_addr;
      wdata_d      = mem_wdata;
      we_d         = 1'b0;
      core_reset_d = core_reset;
      sum_d        = checksum;
      err_d        = frame_err;
      inc_pend_d   = 1'b0;

      // The post-write increment lands while the strobe is up, so the RAM sees the old address.
      if (inc_pend)
         addr_d = mem_addr + ADDR_W'(1);

      case (state)
         IDLE: begin
            core_reset_d = 1'b0;
            if (en_rise) begin
               state_d      = SHIFT;
               cnt_d        = '0;
               sum_d        = '0;
               err_d        = 1'b0;
               addr_d       = '0;
               core_reset_d = 1'b1;
            end
         end
         SHIFT: begin
            if (!en_s) begin
               if (cnt != 4'd0)
                  err_d = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (sclk_rise) begin
               sr_d  = {sr[FW-2:0], sdata_s};
               cnt_d = cnt + 4'd1;
               if (cnt == 4'd15)
                  state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = SHIFT;
            // A bit arriving while the frame is decoded starts the next frame.
            if (sclk_rise) begin
               sr_d  = {sr[FW-2:0], sdata_s};
               cnt_d = 4'd1;
            end else begin
               cnt_d = 4'd0;
            end
            case (cmd)
               CMD_NOP: ;
               CMD_SET_ADDR:
                  addr_d = payload[ADDR_W-1:0];
               CMD_WRITE_INC, CMD_WRITE_HOLD: begin
                  wdata_d    = payload;
                  we_d       = 1'b1;
                  sum_d      = checksum + payload;
                  inc_pend_d = (cmd == CMD_WRITE_INC);
               end
               CMD_END: begin
                  state_d      = DONE;
                  core_reset_d = 1'b0;
               end
               default:
                  err_d = 1'b1;
            endcase
         end
         DONE: begin
            core_reset_d = 1'b0;
            if (!en_s)
               state_d = IDLE;
         end
         default:
            state_d = IDLE;
      endcase
   end

   assign busy = (state == SHIFT) || (state == EXEC);

endmodule

// File: tb/tb_pic_prog_loader.sv
// tb/tb_pic_prog_loader.sv - directed table-driven bench for pic_prog_loader
module tb_pic_prog_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        prog_en = 1'b0;
   logic        prog_sclk = 1'b0;
   logic        prog_sdata = 1'b0;
   logic [8:0]  mem_addr;
   logic [11:0] mem_wdata;
   logic        mem_we;
   logic        core_reset;
   logic        busy;
   logic [11:0] checksum;
   logic        frame_err;

   pic_prog_loader dut (
      .clock(clock), .reset(reset), .prog_en(prog_en), .prog_sclk(prog_sclk),
      .prog_sdata(prog_sdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .core_reset(core_reset), .busy(busy),
      .checksum(checksum), .frame_err(frame_err));

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int               nfr;
      logic [3:0][15:0] fr;
      int               nwr;
      logic [1:0][8:0]  wa;
      logic [1:0][11:0] wd;
      logic [8:0]       addr;
      logic [11:0]      sum;
      logic             err;
   } vec_t;

   vec_t vecs[4];

   logic [8:0]  log_a[$];
   logic [11:0] log_d[$];
   logic        prev_we = 1'b0;

   always @(negedge clock) begin
      if (mem_we === 1'b1) begin
         log_a.push_back(mem_addr);
         log_d.push_back(mem_wdata);
      end
      if (mem_we === 1'b1 && prev_we === 1'b1) begin
         total++;
         bad++;
         $display("FAIL we_back_to_back: mem_we high two cycles at addr %h", mem_addr);
      end
      prev_we = mem_we;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic send_bits(input logic [15:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         prog_sdata = f[15-i];
         prog_sclk  = 1'b0;
         repeat (4) @(negedge clock);
         prog_sclk  = 1'b1;
         repeat (4) @(negedge clock);
      end
      prog_sclk = 1'b0;
   endtask

   task automatic run_vec(input int k);
      log_a.delete();
      log_d.delete();
      prog_en = 1'b1;
      repeat (6) @(negedge clock);
      chk($sformatf("v%0d busy_loading", k), busy, 1);
      chk($sformatf("v%0d core_reset_loading", k), core_reset, 1);
      for (int i = 0; i < vecs[k].nfr; i++)
         send_bits(vecs[k].fr[i], 16);
      repeat (6) @(negedge clock);
      chk($sformatf("v%0d write_count", k), log_a.size(), vecs[k].nwr);
      for (int i = 0; i < vecs[k].nwr; i++) begin
         if (i < log_a.size()) begin
            chk($sformatf("v%0d w%0d_addr", k, i), log_a[i], vecs[k].wa[i]);
            chk($sformatf("v%0d w%0d_data", k, i), log_d[i], vecs[k].wd[i]);
         end
      end
      chk($sformatf("v%0d mem_addr", k), mem_addr, vecs[k].addr);
      chk($sformatf("v%0d checksum", k), checksum, vecs[k].sum);
      chk($sformatf("v%0d frame_err", k), frame_err, vecs[k].err);
      chk($sformatf("v%0d core_reset_done", k), core_reset, 0);
      chk($sformatf("v%0d busy_done", k), busy, 0);
      prog_en = 1'b0;
      repeat (6) @(negedge clock);
      chk($sformatf("v%0d core_reset_idle", k), core_reset, 0);
   endtask

   initial begin
      vecs[0] = '{4, {16'hF000, 16'h2123, 16'h2ABC, 16'h11FE}, 2,
                  {9'h1FF, 9'h1FE}, {12'h123, 12'hABC}, 9'h000, 12'hBDF, 1'b0};
      vecs[1] = '{4, {16'hF000, 16'h3005, 16'h3005, 16'h1010}, 2,
                  {9'h010, 9'h010}, {12'h005, 12'h005}, 9'h010, 12'h00A, 1'b0};
      vecs[2] = '{4, {16'hF000, 16'h2456, 16'h7000, 16'h1020}, 1,
                  {9'h000, 9'h020}, {12'h000, 12'h456}, 9'h021, 12'h456, 1'b1};
      vecs[3] = '{4, {16'hF000, 16'h2FFF, 16'h0123, 16'h1E05}, 1,
                  {9'h000, 9'h005}, {12'h000, 12'hFFF}, 9'h006, 12'hFFF, 1'b0};

      // reset values, then core_reset release one clock after reset drops
      repeat (3) @(negedge clock);
      chk("rst core_reset", core_reset, 1);
      chk("rst mem_we", mem_we, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      chk("rst busy", busy, 0);
      chk("rst checksum", checksum, 0);
      chk("rst frame_err", frame_err, 0);
      reset = 1'b0;
      @(negedge clock);
      chk("rst core_reset_release", core_reset, 0);
      repeat (4) @(negedge clock);
      chk("idle mem_we", mem_we, 0);

      for (int k = 0; k < 4; k++)
         run_vec(k);

      // partial frame: prog_en dropped after 9 bits
      log_a.delete();
      log_d.delete();
      prog_en = 1'b1;
      repeat (6) @(negedge clock);
      send_bits(16'h2004, 16);
      send_bits(16'h2ABC, 9);
      prog_en = 1'b0;
      repeat (8) @(negedge clock);
      chk("drop write_count", log_a.size(), 1);
      chk("drop checksum", checksum, 12'h004);
      chk("drop frame_err", frame_err, 1);
      chk("drop core_reset", core_reset, 0);
      chk("drop busy", busy, 0);
      prog_en = 1'b1;
      repeat (6) @(negedge clock);
      chk("newsess frame_err_clr", frame_err, 0);
      chk("newsess checksum_clr", checksum, 0);
      chk("newsess core_reset", core_reset, 1);
      send_bits(16'hF000, 16);
      repeat (6) @(negedge clock);
      chk("newsess done_busy", busy, 0);
      prog_en = 1'b0;
      repeat (6) @(negedge clock);

      // asynchronous reset in the middle of a WRITE_INC frame
      log_a.delete();
      log_d.delete();
      prog_en = 1'b1;
      repeat (6) @(negedge clock);
      send_bits(16'h1033, 16);
      repeat (2) @(negedge clock);
      chk("mid setaddr", mem_addr, 9'h033);
      send_bits(16'h2ABC, 10);
      #2 reset = 1'b1;
      prog_en = 1'b0;
      #1;
      chk("async mem_addr", mem_addr, 0);
      chk("async mem_wdata", mem_wdata, 0);
      chk("async core_reset", core_reset, 1);
      chk("async busy", busy, 0);
      chk("async mem_we", mem_we, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      chk("async no_write", log_a.size(), 0);
      chk("async core_reset_release", core_reset, 0);

      run_vec(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
